// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller: FSM state encoding,
// coin and change denominations, and price-table slicing.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2
  } vend_state_e;

  localparam int COIN_VAL_A = 1;
  localparam int COIN_VAL_B = 5;
  localparam int COIN_VAL_C = 10;

  localparam int CHG_BIG   = 5;
  localparam int CHG_SMALL = 1;

  // Widest packed price table price_of() accepts; callers zero-extend into it.
  localparam int PT_MAX_W = 1024;

  function automatic logic [31:0] price_of(
    input logic [PT_MAX_W-1:0] tbl,
    input int                  idx,
    input int                  width
  );
    logic [PT_MAX_W-1:0] sh;
    logic [31:0]         mask;
    sh   = tbl >> (idx * width);
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return sh[31:0] & mask;
  endfunction

endpackage

// File: rtl/change_seq.sv
// Change-return step decoder: given the credit still owed, picks the coin to
// eject this cycle and flags the step that empties the credit.
module change_seq
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 8
) (
  input  logic                start,
  input  logic [CREDIT_W-1:0] amount,
  output logic                ret5,
  output logic                ret1,
  output logic                done
);

  always_comb begin
    ret5 = 1'b0;
    ret1 = 1'b0;
    done = 1'b0;
    if (start) begin
      if (amount >= CREDIT_W'(CHG_BIG)) begin
        ret5 = 1'b1;
        done = (amount == CREDIT_W'(CHG_BIG));
      end else if (amount != '0) begin
        ret1 = 1'b1;
        done = (amount == CREDIT_W'(CHG_SMALL));
      end else begin
        // Nothing owed: release straight away rather than stall in CHANGE.
        done = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vend_ctrl.sv
// Vending controller: accumulates coin credit, vends one of N_PROD products
// and sequences change return one coin per cycle. All outputs are registered.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int                          CREDIT_W    = 8,
  parameter int                          N_PROD      = 4,
  parameter logic [N_PROD*CREDIT_W-1:0]  PRICE_TABLE = {8'd7, 8'd5, 8'd4, 8'd3},
  parameter int                          MAX_CREDIT  = 50,
  parameter int                          VAL_A       = COIN_VAL_A,
  parameter int                          VAL_B       = COIN_VAL_B,
  parameter int                          VAL_C       = COIN_VAL_C,
  localparam int                         ID_W        = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          coin,
  input  logic [N_PROD-1:0]   sel,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic                dispense,
  output logic [ID_W-1:0]     dispense_id,
  output logic                ret5,
  output logic                ret1,
  output logic                coin_rej,
  output logic                no_credit,
  output logic                busy,
  output logic [1:0]          state
);

  localparam int SUM_W = CREDIT_W + 1;
  localparam logic [PT_MAX_W-1:0] TBL_EXT = PT_MAX_W'(PRICE_TABLE);

  vend_state_e         state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [ID_W-1:0]     vend_idx_q, vend_idx_d;
  logic                dispense_q, dispense_d;
  logic [ID_W-1:0]     dispense_id_q, dispense_id_d;
  logic                ret5_q, ret5_d;
  logic                ret1_q, ret1_d;
  logic                coin_rej_q, coin_rej_d;
  logic                no_credit_q, no_credit_d;
  logic                busy_q, busy_d;

  logic [CREDIT_W-1:0] price [N_PROD];

  generate
    for (genvar gi = 0; gi < N_PROD; gi++) begin : g_price
      assign price[gi] = CREDIT_W'(price_of(TBL_EXT, gi, CREDIT_W));
    end
  endgenerate

  logic                coin_onehot;
  logic                sel_onehot;
  logic [ID_W-1:0]     sel_idx;
  logic [SUM_W-1:0]    coin_val;
  logic [SUM_W-1:0]    coin_sum;
  logic                coin_fits;
  logic [CREDIT_W-1:0] sel_price;
  logic [CREDIT_W-1:0] vend_rem;

  assign coin_onehot = $onehot(coin);
  assign sel_onehot  = $onehot(sel);

  always_comb begin
    coin_val = '0;
    case (coin)
      3'b001:  coin_val = SUM_W'(VAL_A);
      3'b010:  coin_val = SUM_W'(VAL_B);
      3'b100:  coin_val = SUM_W'(VAL_C);
      default: coin_val = '0;
    endcase
  end

  // One extra bit of headroom so a large coin near the top cannot wrap past the limit.
  assign coin_sum  = {1'b0, credit_q} + coin_val;
  assign coin_fits = (coin_sum <= SUM_W'(MAX_CREDIT));

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < N_PROD; i++) begin
      if (sel[i]) sel_idx = ID_W'(i);
    end
  end

  assign sel_price = price[sel_idx];
  assign vend_rem  = credit_q - price[vend_idx_q];

  logic                chg_active;
  logic                cs_ret5;
  logic                cs_ret1;
  logic                cs_done;
  logic [CREDIT_W-1:0] chg_step;

  assign chg_active = (state_q == CHANGE);

  change_seq #(
    .CREDIT_W (CREDIT_W)
  ) u_change_seq (
    .start  (chg_active),
    .amount (credit_q),
    .ret5   (cs_ret5),
    .ret1   (cs_ret1),
    .done   (cs_done)
  );

  assign chg_step = cs_ret5 ? CREDIT_W'(CHG_BIG) :
                    (cs_ret1 ? CREDIT_W'(CHG_SMALL) : '0);

  logic acted;

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    vend_idx_d    = vend_idx_q;
    dispense_d    = 1'b0;
    dispense_id_d = '0;
    ret5_d        = 1'b0;
    ret1_d        = 1'b0;
    coin_rej_d    = 1'b0;
    no_credit_d   = 1'b0;
    acted         = 1'b0;

    case (state_q)
      IDLE: begin
        if (cancel && (credit_q != '0)) begin
          state_d = CHANGE;
          acted   = 1'b1;
        end else if (sel_onehot) begin
          if (credit_q >= sel_price) begin
            state_d    = VEND;
            vend_idx_d = sel_idx;
            acted      = 1'b1;
          end else begin
            // A refused selection moves no credit, so a coin alongside it is still taken.
            no_credit_d = 1'b1;
          end
        end
        if (coin != '0) begin
          if (acted || !coin_onehot || !coin_fits) begin
            coin_rej_d = 1'b1;
          end else begin
            credit_d = coin_sum[CREDIT_W-1:0];
          end
        end
      end

      VEND: begin
        dispense_d    = 1'b1;
        dispense_id_d = vend_idx_q;
        credit_d      = vend_rem;
        state_d       = (vend_rem != '0) ? CHANGE : IDLE;
        coin_rej_d    = (coin != '0);
      end

      CHANGE: begin
        ret5_d     = cs_ret5;
        ret1_d     = cs_ret1;
        credit_d   = credit_q - chg_step;
        coin_rej_d = (coin != '0);
        if (cs_done) state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      credit_q      <= '0;
      vend_idx_q    <= '0;
      dispense_q    <= 1'b0;
      dispense_id_q <= '0;
      ret5_q        <= 1'b0;
      ret1_q        <= 1'b0;
      coin_rej_q    <= 1'b0;
      no_credit_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      vend_idx_q    <= vend_idx_d;
      dispense_q    <= dispense_d;
      dispense_id_q <= dispense_id_d;
      ret5_q        <= ret5_d;
      ret1_q        <= ret1_d;
      coin_rej_q    <= coin_rej_d;
      no_credit_q   <= no_credit_d;
      busy_q        <= busy_d;
    end
  end

  assign credit      = credit_q;
  assign dispense    = dispense_q;
  assign dispense_id = dispense_id_q;
  assign ret5        = ret5_q;
  assign ret1        = ret1_q;
  assign coin_rej    = coin_rej_q;
  assign no_credit   = no_credit_q;
  assign busy        = busy_q;
  assign state       = state_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Bench for vend_ctrl: a transaction-level model plans expected outputs per
// cycle; a negedge process compares them, directed vectors add literal checks.
module tb_vend_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] coin = '0;
  logic [3:0] sel = '0;
  logic       cancel = 1'b0;
  logic [7:0] credit;
  logic       dispense;
  logic [1:0] dispense_id;
  logic       ret5, ret1, coin_rej, no_credit, busy;
  logic [1:0] state;

  always #5 clk = ~clk;

  vend_ctrl dut (
    .clk         (clk),
    .reset       (rst),
    .coin        (coin),
    .sel         (sel),
    .cancel      (cancel),
    .credit      (credit),
    .dispense    (dispense),
    .dispense_id (dispense_id),
    .ret5        (ret5),
    .ret1        (ret1),
    .coin_rej    (coin_rej),
    .no_credit   (no_credit),
    .busy        (busy),
    .state       (state)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int st;
    int cr;
    bit disp;
    int id;
    bit r5;
    bit r1;
  } ev_t;

  ev_t plan[$];
  int  PRICES[4] = '{3, 4, 5, 7};
  int  m_credit = 0;
  int  e_st = 0, e_cr = 0, e_id = 0;
  bit  e_disp = 0, e_r5 = 0, e_r1 = 0, e_rej = 0, e_nc = 0;
  int  m_val, m_idx, m_rem;
  bit  m_acted;
  ev_t m_ev;

  // Refund of c units: floor(c/5) fives then c mod 5 ones, one per cycle.
  task automatic plan_refund(input int c);
    ev_t ev;
    int  left;
    left = c;
    for (int k = 0; k < c / 5; k++) begin
      left = left - 5;
      ev = '{st: (left == 0) ? 0 : 2, cr: left, disp: 1'b0, id: 0, r5: 1'b1, r1: 1'b0};
      plan.push_back(ev);
    end
    for (int j = 0; j < c % 5; j++) begin
      left = left - 1;
      ev = '{st: (left == 0) ? 0 : 2, cr: left, disp: 1'b0, id: 0, r5: 1'b0, r1: 1'b1};
      plan.push_back(ev);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      plan.delete();
      m_credit = 0;
      e_st = 0; e_cr = 0; e_id = 0;
      e_disp = 0; e_r5 = 0; e_r1 = 0; e_rej = 0; e_nc = 0;
    end else begin
      e_disp = 0; e_r5 = 0; e_r1 = 0; e_rej = 0; e_nc = 0; e_id = 0;
      m_acted = 0;
      if (plan.size() > 0) begin
        m_ev   = plan.pop_front();
        e_st   = m_ev.st;
        e_cr   = m_ev.cr;
        e_disp = m_ev.disp;
        e_id   = m_ev.id;
        e_r5   = m_ev.r5;
        e_r1   = m_ev.r1;
        if (coin != 0) e_rej = 1;
      end else begin
        e_st = 0;
        e_cr = m_credit;
        if (cancel && m_credit > 0) begin
          m_acted = 1;
          e_st = 2;
          plan_refund(m_credit);
          m_credit = 0;
        end else if ($countones(sel) == 1) begin
          m_idx = 0;
          for (int i = 0; i < 4; i++) if (sel[i]) m_idx = i;
          if (m_credit >= PRICES[m_idx]) begin
            m_acted = 1;
            e_st = 1;
            m_rem = m_credit - PRICES[m_idx];
            m_ev = '{st: (m_rem > 0) ? 2 : 0, cr: m_rem, disp: 1'b1, id: m_idx, r5: 1'b0, r1: 1'b0};
            plan.push_back(m_ev);
            plan_refund(m_rem);
            m_credit = 0;
          end else begin
            e_nc = 1;
          end
        end
        if (coin != 0) begin
          m_val = (coin == 3'b001) ? 1 : (coin == 3'b010) ? 5 : (coin == 3'b100) ? 10 : -1;
          if (m_acted || m_val < 0 || m_credit + m_val > 50) begin
            e_rej = 1;
          end else begin
            m_credit = m_credit + m_val;
            e_cr = m_credit;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && chk_en) begin
      cmp("state", int'(state), e_st);
      cmp("credit", int'(credit), e_cr);
      cmp("busy", int'(busy), (e_st != 0) ? 1 : 0);
      cmp("dispense", int'(dispense), int'(e_disp));
      if (e_disp) cmp("dispense_id", int'(dispense_id), e_id);
      cmp("ret5", int'(ret5), int'(e_r5));
      cmp("ret1", int'(ret1), int'(e_r1));
      cmp("coin_rej", int'(coin_rej), int'(e_rej));
      cmp("no_credit", int'(no_credit), int'(e_nc));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic [2:0] c, input logic [3:0] s, input logic k);
    @(negedge clk);
    coin   = c;
    sel    = s;
    cancel = k;
    @(posedge clk);
    #1;
    coin   = '0;
    sel    = '0;
    cancel = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while (state != 2'd0 && n < maxc) begin
      cyc(3'b000, 4'b0000, 1'b0);
      n++;
    end
    cmp("drain_reaches_idle", int'(state), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    cmp("rst_state", int'(state), 0);
    cmp("rst_credit", int'(credit), 0);
    cmp("rst_busy", int'(busy), 0);
    cmp("rst_pulses", int'({dispense, ret5, ret1, coin_rej, no_credit}), 0);
    cmp("rst_dispense_id", int'(dispense_id), 0);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    // Three A coins then exact-price vend of product 0
    repeat (3) cyc(3'b001, 4'b0000, 1'b0);
    cmp("t1_credit", int'(credit), 3);
    cyc(3'b000, 4'b0001, 1'b0);
    cmp("t1_state_vend", int'(state), 1);
    cyc(3'b000, 4'b0000, 1'b0);
    cmp("t1_dispense", int'(dispense), 1);
    cmp("t1_id", int'(dispense_id), 0);
    cmp("t1_credit_after", int'(credit), 0);
    cmp("t1_state_idle", int'(state), 0);
    cyc(3'b000, 4'b0000, 1'b0);

    // Coin C, product 1 (price 4): change 5 then 1
    cyc(3'b100, 4'b0000, 1'b0);
    cmp("t2_credit", int'(credit), 10);
    cyc(3'b000, 4'b0010, 1'b0);
    cmp("t2_state_vend", int'(state), 1);
    cyc(3'b000, 4'b0000, 1'b0);
    cmp("t2_dispense_id", int'(dispense_id), 1);
    cmp("t2_credit_6", int'(credit), 6);
    cyc(3'b000, 4'b0000, 1'b0);
    cmp("t2_ret5", int'(ret5), 1);
    cmp("t2_credit_1", int'(credit), 1);
    cyc(3'b000, 4'b0000, 1'b0);
    cmp("t2_ret1", int'(ret1), 1);
    cmp("t2_credit_0", int'(credit), 0);
    cmp("t2_busy_clear", int'(busy), 0);

    // Credit 7 then cancel: 5, 1, 1 refund
    cyc(3'b010, 4'b0000, 1'b0);
    cyc(3'b001, 4'b0000, 1'b0);
    cyc(3'b001, 4'b0000, 1'b0);
    cmp("t3_credit", int'(credit), 7);
    cyc(3'b000, 4'b0000, 1'b1);
    cmp("t3_state_change", int'(state), 2);
    cyc(3'b000, 4'b0000, 1'b0);
    cmp("t3_ret5", int'(ret5), 1);
    cmp("t3_credit_2", int'(credit), 2);
    cyc(3'b000, 4'b0000, 1'b0);
    cyc(3'b000, 4'b0000, 1'b0);
    cmp("t3_ret1_last", int'(ret1), 1);
    cmp("t3_credit_0", int'(credit), 0);

    // Cancel at zero credit has no effect, so the coin beside it is accepted
    cyc(3'b001, 4'b0000, 1'b1);
    cmp("t4_cancel0_coin_ok", int'(credit), 1);
    cyc(3'b001, 4'b0000, 1'b0);
    cyc(3'b001, 4'b0000, 1'b0);
    cyc(3'b000, 4'b1000, 1'b0);
    cmp("t4_no_credit", int'(no_credit), 1);
    cmp("t4_credit_kept", int'(credit), 3);
    cyc(3'b000, 4'b0011, 1'b0);
    cmp("t4_multisel_ignored", int'({no_credit, busy}), 0);
    cyc(3'b011, 4'b0000, 1'b0);
    cmp("t4_multicoin_rej", int'(coin_rej), 1);
    cmp("t4_multicoin_credit", int'(credit), 3);
    cyc(3'b000, 4'b0000, 1'b1);
    cyc(3'b010, 4'b0000, 1'b0);
    cmp("t4_busy_coin_rej", int'(coin_rej), 1);
    cmp("t4_busy_credit", int'(credit), 2);
    cyc(3'b000, 4'b0001, 1'b1);
    cmp("t4_sel_ignored_in_change", int'(dispense), 0);
    drain(10);

    // Overflow boundary around MAX_CREDIT = 50
    repeat (4) cyc(3'b100, 4'b0000, 1'b0);
    cyc(3'b010, 4'b0000, 1'b0);
    cmp("t5_model_credit", m_credit, 45);
    cmp("t5_credit_45", int'(credit), 45);
    cyc(3'b100, 4'b0000, 1'b0);
    cmp("t5_overflow_rej", int'(coin_rej), 1);
    cmp("t5_overflow_credit", int'(credit), 45);
    cyc(3'b010, 4'b0000, 1'b0);
    cmp("t5_exact_max", int'(credit), 50);
    cyc(3'b001, 4'b0000, 1'b0);
    cmp("t5_over_by_one_rej", int'(coin_rej), 1);
    cyc(3'b010, 4'b0100, 1'b0);
    cmp("t5_sel_coin_rej", int'(coin_rej), 1);
    cmp("t5_sel_state", int'(state), 1);
    cyc(3'b000, 4'b0000, 1'b0);
    cmp("t5_dispense_id", int'(dispense_id), 2);
    cmp("t5_credit_45_after", int'(credit), 45);
    drain(20);
    cmp("t5_credit_end", int'(credit), 0);

    // Asynchronous reset mid-CHANGE
    cyc(3'b100, 4'b0000, 1'b0);
    cyc(3'b001, 4'b0000, 1'b0);
    cyc(3'b001, 4'b0000, 1'b0);
    cyc(3'b000, 4'b0000, 1'b1);
    cmp("t6_state_change", int'(state), 2);
    cyc(3'b000, 4'b0000, 1'b0);
    cmp("t6_first_ret5", int'(ret5), 1);
    cmp("t6_credit_7", int'(credit), 7);
    #2;
    rst = 1'b1;
    #1;
    cmp("t6_async_state", int'(state), 0);
    cmp("t6_async_credit", int'(credit), 0);
    cmp("t6_async_pulses", int'({dispense, ret5, ret1, coin_rej, no_credit, busy}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc(3'b000, 4'b0000, 1'b0);
    cmp("t6_after_reset_idle", int'(state), 0);

    // Recovery: exact-price vend returns straight to IDLE
    cyc(3'b010, 4'b0000, 1'b0);
    cyc(3'b000, 4'b0100, 1'b0);
    cyc(3'b000, 4'b0000, 1'b0);
    cmp("t7_dispense", int'(dispense), 1);
    cmp("t7_direct_idle", int'(state), 0);
    cyc(3'b000, 4'b0000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
